// File: rtl/step_pulse_gen_pkg.sv
// ============================================================================
// Package : step_pulse_gen_pkg
// Desc    : State encodings and width defaults shared with the step-motor ctrl
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package step_pulse_gen_pkg;

  localparam int C_SPEED_DATA_WIDTH_DFLT  = 16;
  localparam int C_STEP_NUMBER_WIDTH_DFLT = 16;
  localparam int C_MIN_PERIOD_DFLT        = 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DRAIN = 3'd4
  } spg_state_t;

endpackage

`default_nettype wire

// File: rtl/step_pulse_gen_period_tick_counter.sv
// ============================================================================
// Module  : period_tick_counter
// Desc    : Loadable down-counter advancing on clk_en ticks, flags count == 1
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module period_tick_counter #(
  parameter int C_COUNT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_clk_en,
  input  logic                     i_load,
  input  logic [C_COUNT_WIDTH-1:0] i_load_val,
  output logic                     o_last
);

  logic [C_COUNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_clk_en && (r_count != '0)) begin
      r_count <= r_count - C_COUNT_WIDTH'(1);
    end
  end

  assign o_last = (r_count == C_COUNT_WIDTH'(1));

endmodule

`default_nettype wire

// File: rtl/step_pulse_gen.sv
// ============================================================================
// Module  : step_pulse_gen
// Desc    : Turns a step count into high/low drive pulses, one period per step
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module step_pulse_gen
  import step_pulse_gen_pkg::*;
#(
  parameter int C_SPEED_DATA_WIDTH  = C_SPEED_DATA_WIDTH_DFLT,
  parameter int C_STEP_NUMBER_WIDTH = C_STEP_NUMBER_WIDTH_DFLT,
  parameter int C_MIN_PERIOD        = C_MIN_PERIOD_DFLT
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           i_clk_en,
  input  logic                           i_start,
  input  logic                           i_stop,
  input  logic                           i_dir,
  input  logic [C_STEP_NUMBER_WIDTH-1:0] i_step_nbr,
  output logic                           o_period_req,
  input  logic                           i_period_valid,
  input  logic [C_SPEED_DATA_WIDTH-1:0]  i_period,
  output logic                           o_drive,
  output logic                           o_dir,
  output logic                           o_busy,
  output logic                           o_done,
  output logic [C_STEP_NUMBER_WIDTH-1:0] o_step_cnt
);

  localparam logic [C_SPEED_DATA_WIDTH-1:0] c_min_p = C_SPEED_DATA_WIDTH'(C_MIN_PERIOD);

  spg_state_t                     r_state;
  logic                           r_start_d1;
  logic                           r_drive;
  logic                           r_dir;
  logic                           r_busy;
  logic                           r_done;
  logic                           r_req;
  logic [C_STEP_NUMBER_WIDTH-1:0] r_step_cnt;
  logic [C_STEP_NUMBER_WIDTH-1:0] r_remain;
  logic [C_SPEED_DATA_WIDTH-1:0]  r_lo;
  logic [C_SPEED_DATA_WIDTH-1:0]  r_buf;
  logic                           r_buf_full;
  logic                           r_outstanding;
  logic                           r_stop_pending;

  logic                           w_start_edge;
  logic                           w_end_move;
  logic [C_SPEED_DATA_WIDTH-1:0]  w_p_src;
  logic [C_SPEED_DATA_WIDTH-1:0]  w_p;
  logic [C_SPEED_DATA_WIDTH-1:0]  w_hi;
  logic [C_SPEED_DATA_WIDTH-1:0]  w_lo;
  logic                           w_cnt_load;
  logic [C_SPEED_DATA_WIDTH-1:0]  w_cnt_val;
  logic                           w_last;

  assign w_start_edge = i_start & ~r_start_d1;
  assign w_end_move   = (r_remain == C_STEP_NUMBER_WIDTH'(1)) | r_stop_pending | i_stop;

  // A buffered period always takes priority; it only exists while in LOW.
  assign w_p_src = r_buf_full ? r_buf : i_period;
  assign w_p     = (w_p_src < c_min_p) ? c_min_p : w_p_src;
  assign w_hi    = w_p >> 1;
  assign w_lo    = w_p - w_hi;

  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = w_hi;
    case (r_state)
      S_FETCH: w_cnt_load = i_period_valid & ~i_stop;
      S_HIGH: begin
        w_cnt_load = i_clk_en & w_last;
        w_cnt_val  = r_lo;
      end
      S_LOW:   w_cnt_load = i_clk_en & w_last & ~w_end_move & (r_buf_full | i_period_valid);
      default: w_cnt_load = 1'b0;
    endcase
  end

  period_tick_counter #(
    .C_COUNT_WIDTH (C_SPEED_DATA_WIDTH)
  ) u_phase_cnt (
    .clk        (clk),
    .reset      (reset),
    .i_clk_en   (i_clk_en),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .o_last     (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_start_d1     <= 1'b0;
      r_drive        <= 1'b0;
      r_dir          <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_req          <= 1'b0;
      r_step_cnt     <= '0;
      r_remain       <= '0;
      r_lo           <= '0;
      r_buf          <= '0;
      r_buf_full     <= 1'b0;
      r_outstanding  <= 1'b0;
      r_stop_pending <= 1'b0;
    end else begin
      r_start_d1 <= i_start;
      r_done     <= 1'b0;
      r_req      <= 1'b0;
      if (i_period_valid) r_outstanding <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_stop_pending <= 1'b0;
          r_buf_full     <= 1'b0;
          if (w_start_edge) begin
            if (i_step_nbr == '0) begin
              r_done <= 1'b1;
            end else begin
              r_remain      <= i_step_nbr;
              r_dir         <= i_dir;
              r_step_cnt    <= '0;
              r_req         <= 1'b1;
              r_outstanding <= 1'b1;
              r_busy        <= 1'b1;
              r_state       <= S_FETCH;
            end
          end
        end

        S_FETCH: begin
          if (i_stop) begin
            if (i_period_valid) begin
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_state <= S_DRAIN;
            end
          end else if (i_period_valid) begin
            r_lo    <= w_lo;
            r_drive <= 1'b1;
            r_state <= S_HIGH;
          end
        end

        S_HIGH: begin
          if (i_stop) r_stop_pending <= 1'b1;
          if (i_clk_en && w_last) begin
            r_drive <= 1'b0;
            r_state <= S_LOW;
            // Prefetch the next period so it is ready by the end of LOW.
            if ((r_remain > C_STEP_NUMBER_WIDTH'(1)) && !i_stop && !r_outstanding) begin
              r_req         <= 1'b1;
              r_outstanding <= 1'b1;
            end
          end
        end

        S_LOW: begin
          if (i_stop) r_stop_pending <= 1'b1;
          if (i_clk_en && w_last) begin
            r_step_cnt <= r_step_cnt + C_STEP_NUMBER_WIDTH'(1);
            r_remain   <= r_remain - C_STEP_NUMBER_WIDTH'(1);
            r_buf_full <= 1'b0;
            if (w_end_move) begin
              if (r_outstanding && !i_period_valid) begin
                r_state <= S_DRAIN;
              end else begin
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
                r_state <= S_IDLE;
              end
            end else if (r_buf_full || i_period_valid) begin
              r_lo    <= w_lo;
              r_drive <= 1'b1;
              r_state <= S_HIGH;
            end else begin
              r_state <= S_FETCH;
            end
          end else if (i_period_valid) begin
            r_buf      <= i_period;
            r_buf_full <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (i_period_valid) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: begin
          r_drive <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_period_req = r_req;
  assign o_drive      = r_drive;
  assign o_dir        = r_dir;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_step_cnt   = r_step_cnt;

endmodule

`default_nettype wire

// File: tb/tb_step_pulse_gen.sv
// ============================================================================
// Module  : tb_step_pulse_gen
// Desc    : Self-checking bench for step_pulse_gen with a period responder
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_clk_en = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic        i_dir = 1'b0;
  logic [15:0] i_step_nbr = '0;
  logic        o_period_req;
  logic        i_period_valid = 1'b0;
  logic [15:0] i_period = '0;
  logic        o_drive;
  logic        o_dir;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_step_cnt;

  step_pulse_gen u_dut (
    .clk            (clk),
    .reset          (reset),
    .i_clk_en       (i_clk_en),
    .i_start        (i_start),
    .i_stop         (i_stop),
    .i_dir          (i_dir),
    .i_step_nbr     (i_step_nbr),
    .o_period_req   (o_period_req),
    .i_period_valid (i_period_valid),
    .i_period       (i_period),
    .o_drive        (o_drive),
    .o_dir          (o_dir),
    .o_busy         (o_busy),
    .o_done         (o_done),
    .o_step_cnt     (o_step_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Responder / monitor state
  int          cyc = 0;
  int          resp_timer = 0;
  int          lat = 2;
  int          ce_pct = 100;
  int          req_cnt = 0;
  int          done_cnt = 0;
  bit          outst = 1'b0;
  bit          done_outst = 1'b0;
  logic [15:0] pend_val = '0;
  int          pq[$];
  int          deliv[$];
  int          hi_q[$];
  int          lo_q[$];
  int          rise_q[$];
  int          hi_cnt = 0;
  int          lo_cnt = 0;
  bit          low_active = 1'b0;
  bit          prev_drive = 1'b0;
  logic [15:0] cnt_at_fall = '0;

  always @(posedge clk) begin
    #1;
    i_period_valid = 1'b0;
    if (resp_timer > 0) begin
      resp_timer--;
      if (resp_timer == 0) begin
        i_period_valid = 1'b1;
        i_period       = pend_val;
      end
    end
    i_clk_en = (ce_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < ce_pct);
  end

  // Outputs sampled mid-cycle; i_clk_en seen here is the tick of the next edge.
  always @(negedge clk) begin
    cyc++;
    if (i_period_valid) outst = 1'b0;
    if (o_done) begin
      done_cnt++;
      done_outst = outst;
    end
    if (o_period_req) begin
      check_eq("req_while_outstanding", outst, 0);
      outst = 1'b1;
      req_cnt++;
      if (pq.size() > 0) pend_val = 16'(pq.pop_front());
      else pend_val = 16'($urandom_range(0, 12));
      deliv.push_back(int'(pend_val));
      resp_timer = lat;
    end
    if (low_active && (o_step_cnt != cnt_at_fall)) begin
      lo_q.push_back(lo_cnt);
      low_active = 1'b0;
    end
    if (o_drive && !prev_drive) begin
      hi_cnt = 0;
      rise_q.push_back(cyc);
    end
    if (o_drive && i_clk_en) hi_cnt++;
    if (!o_drive && prev_drive) begin
      hi_q.push_back(hi_cnt);
      low_active  = 1'b1;
      lo_cnt      = 0;
      cnt_at_fall = o_step_cnt;
    end
    if (low_active && i_clk_en) lo_cnt++;
    if (reset) begin
      resp_timer = 0;
      outst      = 1'b0;
      low_active = 1'b0;
    end
    prev_drive = o_drive;
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_move(int n, bit d);
    hi_q.delete();
    lo_q.delete();
    rise_q.delete();
    deliv.delete();
    req_cnt    = 0;
    done_cnt   = 0;
    done_outst = 1'b0;
    i_step_nbr = 16'(n);
    i_dir      = d;
    i_start    = 1'b1;
    step();
    i_start    = 1'b0;
  endtask

  task automatic wait_done(string tag, int budget);
    int k = 0;
    while (done_cnt == 0 && k < budget) begin
      step();
      k++;
    end
    check_eq($sformatf("%s done_within_budget", tag), (done_cnt > 0), 1);
    step(3);
  endtask

  // Reference: each step uses the next delivered period, clamped to 2 and split hi=p/2, lo=p-hi.
  task automatic check_move(string tag, int exp_steps, int exp_reqs);
    int p, ehi, elo;
    check_eq($sformatf("%s step_cnt", tag), o_step_cnt, exp_steps);
    check_eq($sformatf("%s done_pulses", tag), done_cnt, 1);
    check_eq($sformatf("%s requests", tag), req_cnt, exp_reqs);
    check_eq($sformatf("%s busy_after", tag), o_busy, 0);
    check_eq($sformatf("%s pending_at_done", tag), done_outst, 0);
    check_eq($sformatf("%s high_pulses", tag), hi_q.size(), exp_steps);
    check_eq($sformatf("%s low_phases", tag), lo_q.size(), exp_steps);
    for (int i = 0; i < exp_steps; i++) begin
      if (i < hi_q.size() && i < lo_q.size() && i < deliv.size()) begin
        p   = (deliv[i] < 2) ? 2 : deliv[i];
        ehi = p / 2;
        elo = p - ehi;
        check_eq($sformatf("%s hi_ticks[%0d] p=%0d", tag, i, deliv[i]), hi_q[i], ehi);
        check_eq($sformatf("%s lo_ticks[%0d] p=%0d", tag, i, deliv[i]), lo_q[i], elo);
      end
    end
  endtask

  task automatic check_reset_outputs(string tag);
    check_eq($sformatf("%s drive", tag), o_drive, 0);
    check_eq($sformatf("%s dir", tag), o_dir, 0);
    check_eq($sformatf("%s busy", tag), o_busy, 0);
    check_eq($sformatf("%s done", tag), o_done, 0);
    check_eq($sformatf("%s req", tag), o_period_req, 0);
    check_eq($sformatf("%s step_cnt", tag), o_step_cnt, 0);
  endtask

  initial begin
    int k;
    int n;
    bit d;

    reset = 1'b1;
    step(3);
    check_reset_outputs("reset");
    reset = 1'b0;
    step(2);

    // Back-to-back pulses with prefetch hiding a 2-cycle latency
    lat = 2; ce_pct = 100; pq = '{10, 10, 10};
    start_move(3, 1'b1);
    wait_done("t1", 500);
    check_move("t1", 3, 3);
    check_eq("t1 dir", o_dir, 1);
    check_eq("t1 rises", rise_q.size(), 3);
    if (rise_q.size() == 3) begin
      check_eq("t1 rise_gap1", rise_q[1] - rise_q[0], 10);
      check_eq("t1 rise_gap2", rise_q[2] - rise_q[1], 10);
    end

    // Periods below the floor
    pq = '{1, 0};
    start_move(2, 1'b0);
    wait_done("t2", 500);
    check_move("t2", 2, 2);

    // Long latency: drive stays low in FETCH between pulses
    lat = 20; pq = '{4, 4};
    start_move(2, 1'b0);
    wait_done("t3", 500);
    check_move("t3", 2, 2);
    if (rise_q.size() == 2) check_eq("t3 rise_gap", rise_q[1] - rise_q[0], 23);
    else check_eq("t3 rises", rise_q.size(), 2);

    // Graceful stop during the high phase of step 2
    lat = 8; pq = '{10, 10, 10, 10, 10};
    start_move(5, 1'b0);
    k = 0;
    while (!(o_step_cnt == 16'd1 && o_drive) && k < 300) begin
      step();
      k++;
    end
    check_eq("t4 reached_step2_high", (k < 300), 1);
    i_stop = 1'b1;
    step();
    i_stop = 1'b0;
    wait_done("t4", 500);
    check_move("t4", 2, 3);
    check_eq("t4 response_left", resp_timer, 0);

    // Zero-length move
    start_move(0, 1'b0);
    check_eq("t5 done_next_cycle", o_done, 1);
    step(4);
    check_eq("t5 done_pulses", done_cnt, 1);
    check_eq("t5 requests", req_cnt, 0);
    check_eq("t5 busy", o_busy, 0);

    // Start edge while busy is ignored
    lat = 3; pq = '{6, 6};
    start_move(2, 1'b0);
    step(4);
    i_step_nbr = 16'd7;
    i_start    = 1'b1;
    step();
    i_start    = 1'b0;
    wait_done("t6", 500);
    check_move("t6", 2, 2);

    // Reset in the low phase, then a fresh single-step move
    lat = 2; pq = '{10, 10, 10};
    start_move(3, 1'b1);
    k = 0;
    while (!o_drive && k < 100) begin step(); k++; end
    while (o_drive && k < 100) begin step(); k++; end
    check_eq("t7 reached_low", (k < 100), 1);
    reset = 1'b1;
    step();
    check_reset_outputs("t7 reset");
    reset = 1'b0;
    step(2);
    pq = '{6};
    start_move(1, 1'b0);
    wait_done("t7", 500);
    check_move("t7", 1, 1);

    // Randomized moves
    for (int m = 0; m < 20; m++) begin
      lat = $urandom_range(1, 12);
      case ($urandom_range(0, 2))
        0:       ce_pct = 100;
        1:       ce_pct = 60;
        default: ce_pct = 35;
      endcase
      pq.delete();
      n = $urandom_range(1, 6);
      d = 1'($urandom_range(0, 1));
      start_move(n, d);
      wait_done($sformatf("rnd%0d", m), 3000);
      check_move($sformatf("rnd%0d", m), n, n);
      check_eq($sformatf("rnd%0d dir", m), o_dir, d);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
